// File: rtl/colour_table_fader.sv
// colour_table_fader: AXI-Lite master that fades a run of RGB565 colour
// table entries. Each entry is read, every channel is scaled by a
// brightness factor (256 = unity) and the result is written back. Only one
// entry is in flight at a time.
module colour_table_fader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 13
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [8:0]             factor,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH-1:0]  m_axil_awaddr,
  output logic [2:0]             m_axil_awprot,
  output logic                   m_axil_awvalid,
  input  logic                   m_axil_awready,
  output logic [DATA_WIDTH-1:0]  m_axil_wdata,
  output logic [1:0]             m_axil_wstrb,
  output logic                   m_axil_wvalid,
  input  logic                   m_axil_wready,
  input  logic                   m_axil_bvalid,
  output logic                   m_axil_bready,
  output logic [ADDR_WIDTH-1:0]  m_axil_araddr,
  output logic [2:0]             m_axil_arprot,
  output logic                   m_axil_arvalid,
  input  logic                   m_axil_arready,
  input  logic [DATA_WIDTH-1:0]  m_axil_rdata,
  input  logic [1:0]             m_axil_rresp,
  input  logic                   m_axil_rvalid,
  output logic                   m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_CALC,
    S_WR,
    S_B,
    S_FINISH
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] total;   // entries in this run
  logic [COUNT_WIDTH-1:0] index;   // entry currently being processed
  logic [8:0]             gain;    // clamped factor, 0..256
  logic [DATA_WIDTH-1:0]  pixel;   // entry as read from the table

  // Unprivileged, non-secure data accesses; every write covers the whole entry.
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = 2'b11;

  // Channel scaling: (c * f) >> 8. With f <= 256 the result never exceeds c,
  // so truncation to the channel width cannot overflow.
  function automatic logic [4:0] scale5(input logic [4:0] c, input logic [8:0] f);
    return 5'((14'(c) * 14'(f)) >> 8);
  endfunction

  function automatic logic [5:0] scale6(input logic [5:0] c, input logic [8:0] f);
    return 6'((15'(c) * 15'(f)) >> 8);
  endfunction

  function automatic logic [15:0] fade(input logic [15:0] p, input logic [8:0] f);
    return {scale5(p[15:11], f), scale6(p[10:5], f), scale5(p[4:0], f)};
  endfunction

  // Sequencer: start accept, AR -> R -> CALC -> WR -> B per entry, then FINISH.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= S_IDLE;
      total          <= '0;
      index          <= '0;
      gain           <= '0;
      pixel          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values, independent of statement order in this block.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            // The read address register doubles as the running entry pointer.
            m_axil_araddr <= base_addr & ~ADDR_WIDTH'(1);
            total         <= count;
            gain          <= (factor > 9'd256) ? 9'd256 : factor;
            index         <= '0;
            error         <= 1'b0;
            if (count == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state          <= S_AR;
              busy           <= 1'b1;
              m_axil_arvalid <= 1'b1;
            end
          end
        end

        S_AR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= S_R;
          end
        end

        S_R: begin
          if (m_axil_rvalid) begin
            pixel         <= m_axil_rdata;
            m_axil_rready <= 1'b0;
            // A bad response is recorded but the run carries on regardless.
            if (m_axil_rresp != 2'b00) error <= 1'b1;
            state <= S_CALC;
          end
        end

        S_CALC: begin
          m_axil_wdata   <= fade(pixel, gain);
          m_axil_awaddr  <= m_axil_araddr;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid  <= 1'b1;
          state          <= S_WR;
        end

        S_WR: begin
          // Each channel drops its valid on its own handshake; the phase ends
          // once both are gone, whether they completed together or apart.
          if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready) m_axil_wvalid <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state         <= S_B;
          end
        end

        S_B: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            if (COUNT_WIDTH'(index + 1'b1) == total) begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index          <= index + 1'b1;
              m_axil_araddr  <= m_axil_araddr + ADDR_WIDTH'(2);
              m_axil_arvalid <= 1'b1;
              state          <= S_AR;
            end
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/colour_table_fader.md
Name: colour_table_fader

Overview:
- AXI-Lite master that performs a palette fade. It walks a contiguous range of colour table entries, scaling each RGB565 entry by a brightness factor, through a read-modify-write sequence over the colour table's AXI-Lite slave port.
- Sits between the CPU-side control registers and the colour table, on the table's AXI-Lite port. The portb display read path is untouched.
- One entry in flight at a time; strictly sequential transactions.

Parameters:
- ADDR_WIDTH, 16, byte address width of the AXI-Lite master.
- DATA_WIDTH, 16, data width; fixed at 16 (RGB565).
- COUNT_WIDTH, 13, width of the entry count; allows up to 4096 entries plus headroom.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle start pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  byte address of the first entry; bit 0 ignored
- count  in  COUNT_WIDTH  number of entries to process
- factor  in  9  brightness factor; 256 = unity, values >256 clamp to 256
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the run finishes
- error  out  1  sticky; set on rresp != 0; cleared by the next accepted start
- m_axil_awaddr  out  ADDR_WIDTH ; m_axil_awprot out 3 (always 0) ; m_axil_awvalid out 1 ; m_axil_awready in 1
- m_axil_wdata  out  DATA_WIDTH ; m_axil_wstrb out 2 (always 2'b11) ; m_axil_wvalid out 1 ; m_axil_wready in 1
- m_axil_bvalid  in  1 ; m_axil_bready out 1
- m_axil_araddr  out  ADDR_WIDTH ; m_axil_arprot out 3 (always 0) ; m_axil_arvalid out 1 ; m_axil_arready in 1
- m_axil_rdata  in  DATA_WIDTH ; m_axil_rresp in 2 ; m_axil_rvalid in 1 ; m_axil_rready out 1

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - All valid/ready outputs, busy, done and error go to 0.
  - Address and data registers go to 0.
  - Reset mid-run abandons the run with no done pulse; an outstanding slave transaction is not completed.
- Start accept:
  - In IDLE, start=1 latches base_addr (bit 0 forced 0), count, clamped factor, and clears error and the index.
  - If the latched count = 0: go to FINISH directly, with no bus traffic.
  - Otherwise go to AR.
  - start outside IDLE is ignored. Inputs are not resampled during a run.
- Address of entry i = base + 2*i, modulo 2^ADDR_WIDTH (wraps).
- States:
  - IDLE.
  - AR: arvalid=1, araddr stable until arready. On handshake go to R.
  - R: rready=1. On rvalid, capture rdata, set error if rresp != 0, and go to CALC.
  - CALC: one cycle. Compute the result into the wdata register; go to WR.
  - WR:
    - awvalid and wvalid are raised together.
    - Each drops independently on its own handshake, with address and data held stable until then.
    - When both handshakes are done (same or different cycles), go to B.
  - B: bready=1. On bvalid:
    - If index+1 == count: go to FINISH.
    - Otherwise increment the index and go to AR.
  - FINISH: done=1 and busy=0 in this cycle; go to IDLE.
- Valids are never withdrawn before their handshake.
- Arithmetic, with f the clamped factor (0..256):
  - R5 = rdata[15:11], G6 = rdata[10:5], B5 = rdata[4:0].
  - Each channel c' = (c*f) >> 8, truncating.
  - No saturation is needed because f <= 256. f=256 is the identity; f=0 gives 0x0000.
- Latency per entry with an always-ready slave: AR 1 + R 1 (or as slave delays) + CALC 1 + WR 1 + B 1 cycles.
- busy is high in all states except IDLE and FINISH.
- An error does not stop the run; the faded garbage value is written back.

Test Plan:
- base=0x0010, count=1, f=128, table[8]=0xFFFF -> one read at 0x0010, one write of 0x7BEF at 0x0010, done pulse, error=0.
- count=3, f=256, entries 0x1234/0xABCD/0x0001 -> each entry is written back unchanged; addresses 0x0010, 0x0012, 0x0014 in order; exactly 3 B handshakes.
- f=0 and f=300 on entry 0xF81F -> f=0 writes 0x0000; f=300 (clamped to 256) writes 0xF81F.
- count=0 -> done high 1 cycle after start (busy stays 0 for that cycle pair); no arvalid/awvalid ever asserted.
- Backpressure:
  - arready low for 5 cycles -> arvalid held and araddr stable throughout.
  - awready granted 3 cycles before wready -> awvalid drops after its handshake, wvalid persists with wdata stable, B is entered only after the W handshake.
- Wrap and reset:
  - base=0xFFFE, count=2 -> addresses 0xFFFE then 0x0000.
  - rresp=2'b10 on the second read -> error=1 at done and stays 1 until the next start.
  - areset asserted during WR -> all valids 0 immediately, no done pulse, IDLE on release.
